// File: rtl/ballot_unit.sv
// Voter-side ballot entry: conditions candidate/confirm/cancel buttons, enforces one
// vote per ballot issue and hands a 4-bit candidate code to the counter via valid/ack.
module ballot_unit #(
   parameter int unsigned DEB_CYCLES     = 16,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        enable,
   input  logic [15:1] key,
   input  logic        confirm,
   input  logic        cancel,
   input  logic        vote_ack,
   output logic        ready,
   output logic [3:0]  sel_code,
   output logic [3:0]  vote_code,
   output logic        vote_valid,
   output logic        err,
   output logic        cast_done
);

   localparam int unsigned NK = 15;
   localparam int unsigned CW = $clog2(DEB_CYCLES + 1);
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);
   localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {S_IDLE, S_ARMED, S_SELECT, S_CAST, S_RELEASE} state_e;

   logic [NK:1]         key_s1_q, key_s2_q;
   logic [NK:1]         key_cand_q, key_cand_d, key_deb_q, key_deb_d;
   logic [CW-1:0]       key_cnt_q, key_cnt_d;
   // control channel 0 = confirm, 1 = cancel
   logic [1:0]          ctl_s1_q, ctl_s2_q, ctl_prev_q;
   logic [1:0]          ctl_cand_q, ctl_cand_d, ctl_deb_q, ctl_deb_d;
   logic [1:0][CW-1:0]  ctl_cnt_q, ctl_cnt_d;

   state_e              state_q, state_d;
   logic [TW-1:0]       timer_q, timer_d;
   logic [3:0]          sel_code_d, vote_code_d;
   logic                ready_d, vote_valid_d, err_d, cast_done_d;

   logic [3:0]          key_code_c;
   logic                key_any_c, key_onehot_c, key_multi_c;
   logic                conf_evt_c, canc_evt_c;

   // Key word debouncer: accept a value once the synchronized word held it DEB_CYCLES cycles
   always_comb begin
      key_cand_d = key_cand_q;
      key_cnt_d  = key_cnt_q;
      key_deb_d  = key_deb_q;
      if (key_s2_q != key_cand_q) begin
         key_cand_d = key_s2_q;
         key_cnt_d  = CW'(1);
      end else if (key_cand_q != key_deb_q) begin
         if (key_cnt_q == CNT_LAST) key_deb_d = key_cand_q;
         else                       key_cnt_d = key_cnt_q + CW'(1);
      end
   end

   // Confirm / cancel debouncers, same rule per channel
   always_comb begin
      ctl_cand_d = ctl_cand_q;
      ctl_cnt_d  = ctl_cnt_q;
      ctl_deb_d  = ctl_deb_q;
      for (int i = 0; i < 2; i++) begin
         if (ctl_s2_q[i] != ctl_cand_q[i]) begin
            ctl_cand_d[i] = ctl_s2_q[i];
            ctl_cnt_d[i]  = CW'(1);
         end else if (ctl_cand_q[i] != ctl_deb_q[i]) begin
            if (ctl_cnt_q[i] == CNT_LAST) ctl_deb_d[i] = ctl_cand_q[i];
            else                          ctl_cnt_d[i] = ctl_cnt_q[i] + CW'(1);
         end
      end
   end

   always_comb begin
      key_code_c = '0;
      for (int i = 1; i <= 15; i++) begin
         if (key_deb_q[i]) key_code_c = 4'(i);
      end
      key_any_c    = |key_deb_q;
      key_onehot_c = key_any_c && ((key_deb_q & (key_deb_q - NK'(1))) == '0);
      key_multi_c  = key_any_c && !key_onehot_c;
   end

   assign conf_evt_c = ctl_deb_q[0] & ~ctl_prev_q[0];
   assign canc_evt_c = ctl_deb_q[1] & ~ctl_prev_q[1];

   // Ballot FSM; outputs are derived from the next state so they register with it
   always_comb begin
      state_d    = state_q;
      sel_code_d = sel_code;
      timer_d    = timer_q;
      case (state_q)
         S_IDLE: begin
            sel_code_d = '0;
            if (enable) state_d = S_ARMED;
         end
         S_ARMED: begin
            if (key_onehot_c) begin
               sel_code_d = key_code_c;
               timer_d    = '0;
               state_d    = S_SELECT;
            end
         end
         S_SELECT: begin
            timer_d = (timer_q == TMR_LAST) ? timer_q : timer_q + TW'(1);
            if (canc_evt_c) begin
               sel_code_d = '0;
               state_d    = S_ARMED;
            end else if (conf_evt_c) begin
               state_d = S_CAST;
            end else if (key_onehot_c && (key_code_c != sel_code)) begin
               sel_code_d = key_code_c;
               timer_d    = '0;
            end else if (timer_q == TMR_LAST) begin
               sel_code_d = '0;
               state_d    = S_ARMED;
            end
         end
         S_CAST: begin
            if (vote_ack) begin
               sel_code_d = '0;
               state_d    = S_RELEASE;
            end
         end
         S_RELEASE: begin
            sel_code_d = '0;
            if (!key_any_c && !ctl_deb_q[0]) state_d = S_IDLE;
         end
         default: begin
            sel_code_d = '0;
            state_d    = S_IDLE;
         end
      endcase

      ready_d      = (state_d == S_ARMED) || (state_d == S_SELECT);
      err_d        = key_multi_c && ready_d;
      vote_valid_d = (state_d == S_CAST);
      vote_code_d  = vote_valid_d ? sel_code_d : 4'd0;
      cast_done_d  = (state_q == S_RELEASE) && (state_d == S_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         key_s1_q   <= '0;
         key_s2_q   <= '0;
         key_cand_q <= '0;
         key_deb_q  <= '0;
         key_cnt_q  <= '0;
         ctl_s1_q   <= '0;
         ctl_s2_q   <= '0;
         ctl_cand_q <= '0;
         ctl_deb_q  <= '0;
         ctl_cnt_q  <= '0;
         ctl_prev_q <= '0;
         state_q    <= S_IDLE;
         timer_q    <= '0;
         sel_code   <= '0;
         vote_code  <= '0;
         ready      <= 1'b0;
         vote_valid <= 1'b0;
         err        <= 1'b0;
         cast_done  <= 1'b0;
      end else begin
         key_s1_q   <= key;
         key_s2_q   <= key_s1_q;
         key_cand_q <= key_cand_d;
         key_deb_q  <= key_deb_d;
         key_cnt_q  <= key_cnt_d;
         ctl_s1_q   <= {cancel, confirm};
         ctl_s2_q   <= ctl_s1_q;
         ctl_cand_q <= ctl_cand_d;
         ctl_deb_q  <= ctl_deb_d;
         ctl_cnt_q  <= ctl_cnt_d;
         ctl_prev_q <= ctl_deb_q;
         state_q    <= state_d;
         timer_q    <= timer_d;
         sel_code   <= sel_code_d;
         vote_code  <= vote_code_d;
         ready      <= ready_d;
         vote_valid <= vote_valid_d;
         err        <= err_d;
         cast_done  <= cast_done_d;
      end
   end

endmodule
